// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between one requester and its completers.
// The master modport drives the request; the slave modport answers with PREADY/PRDATA.
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SLV_COUNT  = 4
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [SLV_COUNT-1:0]  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PREADY, PRDATA
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PREADY, PRDATA
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory.
// Answers on one PSEL bit with a fixed number of PREADY-low wait states.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SLV_COUNT   = 4,
    parameter int SLV_IDX     = 0,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_slave_mem_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      wordIdx_q, wordIdx_d;
    logic                  isWrite_q, isWrite_d;
    logic                  outOfRange_q, outOfRange_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic             sel;
    logic [IDX_W-1:0] reqIdx;
    logic             reqOor;
    logic             commitWrite;
    logic             unused_ok;

    assign sel       = bus.PSEL[SLV_IDX];
    assign reqIdx    = bus.PADDR[IDX_W+1:2];
    assign reqOor    = |(bus.PADDR >> (IDX_W + 2));
    assign unused_ok = ^{bus.PADDR[1:0], bus.PSEL};

    assign bus.PREADY = pready_q;
    assign bus.PRDATA = prdata_q;

    // Address and direction are captured only in the setup cycle; the access
    // phase works from the latched copies so late bus changes are ignored.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wordIdx_d    = wordIdx_q;
        isWrite_d    = isWrite_q;
        outOfRange_d = outOfRange_q;
        prdata_d     = prdata_q;
        commitWrite  = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel && !bus.PENABLE) begin
                    wordIdx_d    = reqIdx;
                    isWrite_d    = bus.PWRITE;
                    outOfRange_d = reqOor;
                    if (WS == 4'd0) begin
                        state_d = READY;
                    end else begin
                        cnt_d   = WS;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (sel && bus.PENABLE) begin
                    cnt_d = 4'(cnt_q - 4'd1);
                    if (cnt_q == 4'd1) begin
                        state_d = READY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READY: begin
                state_d     = IDLE;
                commitWrite = sel && bus.PENABLE && isWrite_q && !outOfRange_q;
            end
            default: state_d = IDLE;
        endcase

        // Read data is fetched on the edge that enters READY.
        if (state_d == READY && state_q != READY && !isWrite_d) begin
            prdata_d = outOfRange_d ? '0 : mem_q[wordIdx_d];
        end

        pready_d = (state_d == READY);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wordIdx_q    <= '0;
            isWrite_q    <= 1'b0;
            outOfRange_q <= 1'b0;
            pready_q     <= 1'b0;
            prdata_q     <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wordIdx_q    <= wordIdx_d;
            isWrite_q    <= isWrite_d;
            outOfRange_q <= outOfRange_d;
            pready_q     <= pready_d;
            prdata_q     <= prdata_d;
            if (commitWrite) begin
                mem_q[wordIdx_q] <= bus.PWDATA;
            end
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with one wait state, one with none.
// Both share the bus drive; useB routes PSEL and the sampled response to one of them.
module tb_apb_slave_mem;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic        pwrite = 1'b0;
    logic        penable = 1'b0;
    logic [3:0]  psel = '0;
    bit          useB = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          cycleCount = 0;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cycleCount++;

    apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(4)) ifA ();
    apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(4)) ifB ();

    assign ifA.PADDR   = paddr;
    assign ifA.PWRITE  = pwrite;
    assign ifA.PENABLE = penable;
    assign ifA.PWDATA  = pwdata;
    assign ifA.PSEL    = useB ? 4'b0000 : psel;
    assign ifB.PADDR   = paddr;
    assign ifB.PWRITE  = pwrite;
    assign ifB.PENABLE = penable;
    assign ifB.PWDATA  = pwdata;
    assign ifB.PSEL    = useB ? psel : 4'b0000;

    apb_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(4), .SLV_IDX(0),
        .MEM_DEPTH(256), .WAIT_STATES(1)
    ) dutA (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (ifA)
    );

    apb_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(4), .SLV_IDX(0),
        .MEM_DEPTH(256), .WAIT_STATES(0)
    ) dutB (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (ifB)
    );

    logic        curReady;
    logic [31:0] curData;
    assign curReady = useB ? ifB.PREADY : ifA.PREADY;
    assign curData  = useB ? ifB.PRDATA : ifA.PRDATA;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full transfer; the access phase scrambles PADDR/PWRITE to prove they are latched.
    task automatic applyStimulus(input logic [3:0] selVec, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output int accessCycles);
        @(negedge PCLK);
        checkOutput("pready_low_before_setup", 32'(curReady), 32'd0);
        psel    = selVec;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(negedge PCLK);
        penable = 1'b1;
        paddr   = ~addr;
        pwrite  = ~wr;
        accessCycles = 1;
        while (!curReady && accessCycles < 20) begin
            @(negedge PCLK);
            accessCycles++;
        end
        rdata = curData;
    endtask

    task automatic idleBus();
        @(negedge PCLK);
        psel    = '0;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
    endtask

    task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data, input int expCycles);
        logic [31:0] rd;
        int          cyc;
        applyStimulus(4'b0001, 1'b1, addr, data, rd, cyc);
        checkOutput(tag, 32'(cyc), 32'(expCycles));
    endtask

    task automatic doRead(input string tag, input logic [31:0] addr, input logic [31:0] expData, input int expCycles);
        logic [31:0] rd;
        int          cyc;
        applyStimulus(4'b0001, 1'b0, addr, 32'h0, rd, cyc);
        checkOutput({tag, "_cycles"}, 32'(cyc), 32'(expCycles));
        checkOutput({tag, "_data"}, rd, expData);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          c1;
        logic        sawReady;

        repeat (2) @(negedge PCLK);
        checkOutput("reset_pready_a", 32'(ifA.PREADY), 32'd0);
        checkOutput("reset_prdata_a", ifA.PRDATA, 32'd0);
        checkOutput("reset_pready_b", 32'(ifB.PREADY), 32'd0);
        checkOutput("reset_prdata_b", ifB.PRDATA, 32'd0);
        PRESET = 1'b0;

        doRead("rd_0x10_after_reset", 32'h10, 32'h0, 2);
        idleBus();

        doWrite("wr_0x04_cycles", 32'h04, 32'hDEADBEEF, 2);
        doRead("rd_0x04", 32'h04, 32'hDEADBEEF, 2);
        idleBus();
        doRead("rd_0x07_low_bits_ignored", 32'h07, 32'hDEADBEEF, 2);
        idleBus();

        doWrite("wr_oor_cycles", 32'h400, 32'hA5A5A5A5, 2);
        idleBus();
        doRead("rd_oor", 32'h400, 32'h0, 2);
        idleBus();
        doRead("rd_0x00_after_oor", 32'h000, 32'h0, 2);
        idleBus();

        applyStimulus(4'b0010, 1'b1, 32'h14, 32'h77, rd, cyc);
        checkOutput("other_sel_no_pready", 32'(cyc), 32'd20);
        idleBus();
        doRead("rd_0x14_after_other_sel", 32'h14, 32'h0, 2);
        idleBus();

        doWrite("wr_0x0c_cycles", 32'h0C, 32'h12345678, 2);
        idleBus();
        @(negedge PCLK);
        psel    = 4'b0001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h55;
        @(negedge PCLK);
        sawReady = curReady;
        psel     = '0;
        penable  = 1'b0;
        repeat (2) begin
            @(negedge PCLK);
            sawReady = sawReady | curReady;
        end
        checkOutput("abort_no_pready", 32'(sawReady), 32'd0);
        doRead("rd_0x0c_after_abort", 32'h0C, 32'h12345678, 2);
        idleBus();

        @(negedge PCLK);
        psel    = 4'b0001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h04;
        pwdata  = 32'h99;
        @(negedge PCLK);
        penable = 1'b1;
        PRESET  = 1'b1;
        @(negedge PCLK);
        checkOutput("midop_reset_pready", 32'(ifA.PREADY), 32'd0);
        checkOutput("midop_reset_prdata", ifA.PRDATA, 32'd0);
        PRESET  = 1'b0;
        psel    = '0;
        penable = 1'b0;
        doRead("rd_0x04_after_reset", 32'h04, 32'h0, 2);
        idleBus();

        useB = 1'b1;
        idleBus();
        doWrite("b_wr_0x08_cycles", 32'h08, 32'h11, 1);
        c1 = cycleCount;
        doRead("b_rd_0x08", 32'h08, 32'h11, 1);
        checkOutput("b_back_to_back_span", 32'(cycleCount - c1), 32'd2);
        idleBus();
        @(negedge PCLK);
        checkOutput("b_pready_idle", 32'(curReady), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
